// File: rtl/tdm_demux1b1to4.sv
// tdm_demux1b1to4: frame-synced 1:4 TDM demultiplexer publishing coherent 4-slot frames
module tdm_demux1b1to4 #(
  parameter int W = 1,
  parameter int MISS_LIMIT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         sync,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic         frame_valid,
  output logic         s1,
  output logic         s2,
  output logic         locked,
  output logic         sync_err
);
  localparam logic HUNT = 1'b0;
  localparam logic LOCKED = 1'b1;
  localparam logic [2:0] ML = 3'(MISS_LIMIT);
  logic         r_state;
  logic [1:0]   r_slot;
  logic [2:0]   r_miss;
  logic [W-1:0] r_sh0, r_sh1, r_sh2;
  logic [2:0]   w_miss_nxt;
  assign w_miss_nxt = r_miss + 3'd1;
  assign locked = r_state;
  assign {s1, s2} = r_slot;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HUNT;
      r_slot <= '0;
      r_miss <= '0;
      r_sh0 <= '0;
      r_sh1 <= '0;
      r_sh2 <= '0;
      a <= '0;
      b <= '0;
      c <= '0;
      d <= '0;
      frame_valid <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err <= 1'b0;
      if (din_valid) begin
        if (r_state == HUNT) begin
          if (sync) begin
            r_sh0 <= din;
            r_slot <= 2'd1;
            r_miss <= '0;
            r_state <= LOCKED;
          end
        end else if (sync) begin
          // a sync anywhere but slot 0 restarts the frame from this beat
          sync_err <= (r_slot != 2'd0);
          r_sh0 <= din;
          r_slot <= 2'd1;
          r_miss <= '0;
        end else if (r_slot == 2'd0 && w_miss_nxt == ML) begin
          r_state <= HUNT;
          r_slot <= '0;
          r_miss <= '0;
        end else begin
          if (r_slot == 2'd0) r_miss <= w_miss_nxt;
          if (r_slot == 2'd3) begin
            a <= r_sh0;
            b <= r_sh1;
            c <= r_sh2;
            d <= din;
            frame_valid <= 1'b1;
            r_slot <= 2'd0;
          end else begin
            r_slot <= r_slot + 2'd1;
            if (r_slot == 2'd0) r_sh0 <= din;
            if (r_slot == 2'd1) r_sh1 <= din;
            if (r_slot == 2'd2) r_sh2 <= din;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_tdm_demux1b1to4.sv
// tb_tdm_demux1b1to4: scoreboard bench for the TDM demux at W=1 and W=4
module tb_tdm_demux1b1to4;
  logic clk = 0, rst = 0;
  logic din1 = 0, v1 = 0, sy1 = 0;
  logic a1, b1, c1, d1, fv1, s11, s21, lk1, se1;
  logic [3:0] din4 = 0;
  logic v4 = 0, sy4 = 0;
  logic [3:0] a4, b4, c4, d4;
  logic fv4, s14, s24, lk4, se4;
  int n_cmp = 0, n_bad = 0, n_se = 0;
  logic [3:0] q1[$];
  logic [15:0] q4[$];

  tdm_demux1b1to4 #(.W(1), .MISS_LIMIT(2)) u1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(v1), .sync(sy1),
    .a(a1), .b(b1), .c(c1), .d(d1), .frame_valid(fv1),
    .s1(s11), .s2(s21), .locked(lk1), .sync_err(se1));

  tdm_demux1b1to4 #(.W(4), .MISS_LIMIT(2)) u4 (
    .clk(clk), .rst(rst), .din(din4), .din_valid(v4), .sync(sy4),
    .a(a4), .b(b4), .c(c4), .d(d4), .frame_valid(fv4),
    .s1(s14), .s2(s24), .locked(lk4), .sync_err(se4));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (fv1) begin
      if (q1.size() == 0) chk("frame1_unexpected", 32'({a1, b1, c1, d1}), 32'hFFFF_FFFF);
      else chk("frame1", 32'({a1, b1, c1, d1}), 32'(q1.pop_front()));
    end
    if (fv4) begin
      if (q4.size() == 0) chk("frame4_unexpected", 32'({a4, b4, c4, d4}), 32'hFFFF_FFFF);
      else chk("frame4", 32'({a4, b4, c4, d4}), 32'(q4.pop_front()));
    end
    if (se1) n_se++;
  end

  task automatic beat1(input logic d, input logic s);
    din1 = d; sy1 = s; v1 = 1;
    @(posedge clk); #1;
    v1 = 0; sy1 = 0;
  endtask

  task automatic beat4(input logic [3:0] d, input logic s);
    din4 = d; sy4 = s; v4 = 1;
    @(posedge clk); #1;
    v4 = 0; sy4 = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic st1(input logic [1:0] s, input logic lk);
    chk("slot1", 32'({s11, s21}), 32'(s));
    chk("locked1", 32'(lk1), 32'(lk));
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    do_reset();
    chk("rst_abcd1", 32'({a1, b1, c1, d1}), 0);
    chk("rst_fv1", 32'(fv1), 0);
    chk("rst_se1", 32'(se1), 0);
    st1(2'b00, 0);
    chk("rst_abcd4", 32'({a4, b4, c4, d4}), 0);
    chk("rst_lk4", 32'(lk4), 0);
    beat4(4'hA, 1); beat4(4'h5, 0); beat4(4'h3, 0);
    chk("fv4_early", 32'(fv4), 0);
    q4.push_back(16'hA53C);
    beat4(4'hC, 0);
    chk("fv4_latency", 32'(fv4), 1);
    beat1(0, 1); st1(2'b01, 1);
    beat1(1, 0); st1(2'b10, 1);
    beat1(0, 0); st1(2'b11, 1);
    q1.push_back(4'b0101);
    beat1(1, 0); st1(2'b00, 1);
    chk("fv1_cont", 32'(fv1), 1);
    beat1(0, 1); idle(1); st1(2'b01, 1);
    beat1(1, 0); idle(3); st1(2'b10, 1);
    beat1(0, 0); idle(2); st1(2'b11, 1);
    q1.push_back(4'b0101);
    beat1(1, 0);
    chk("fv1_gap", 32'(fv1), 1);
    idle(1);
    chk("fv1_gap_drop", 32'(fv1), 0);
    chk("abcd1_hold", 32'({a1, b1, c1, d1}), 32'h5);
    beat1(1, 1); beat1(0, 0); beat1(0, 1);
    chk("se1_slot2", 32'(se1), 1);
    st1(2'b01, 1);
    beat1(1, 0);
    chk("se1_drop", 32'(se1), 0);
    q1.push_back(4'b0110);
    beat1(1, 0); beat1(0, 0);
    beat1(1, 1); beat1(1, 0); beat1(1, 0); beat1(0, 1);
    chk("se1_slot3", 32'(se1), 1);
    chk("fv1_slot3", 32'(fv1), 0);
    q1.push_back(4'b0101);
    beat1(1, 0); beat1(0, 0); beat1(1, 0);
    beat1(1, 0); st1(2'b01, 1);
    beat1(0, 0); beat1(0, 0);
    q1.push_back(4'b1001);
    beat1(1, 0);
    beat1(1, 0); st1(2'b00, 0);
    beat1(1, 0); beat1(1, 0); beat1(1, 0); st1(2'b00, 0);
    q1.push_back(4'b0011);
    beat1(0, 1); beat1(0, 0); beat1(1, 0); beat1(1, 0);
    beat1(1, 1); beat1(0, 0);
    do_reset();
    chk("midrst_abcd1", 32'({a1, b1, c1, d1}), 0);
    chk("midrst_fv1", 32'(fv1), 0);
    st1(2'b00, 0);
    beat1(1, 0); beat1(1, 0); st1(2'b00, 0);
    q1.push_back(4'b1111);
    beat1(1, 1); beat1(1, 0); beat1(1, 0); beat1(1, 0);
    chk("relock1", 32'(lk1), 1);
    idle(3);
    chk("q1_drained", 32'(q1.size()), 0);
    chk("q4_drained", 32'(q4.size()), 0);
    chk("se1_pulses", 32'(n_se), 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
